// File: rtl/tetris_pkg.sv
// tetris_pkg: constants shared by the key input front end and the game logic.
//   KEY_*            : bit position of each button in the keys_n / cmd_pulse / held vectors
//   ST_*             : per-button channel state encoding
//   DEF_*            : default timing in 10 ms ticks (at 100 Hz)
//   timer_width()    : width of the DAS/ARR timer, at least 1 bit
package tetris_pkg;

  localparam int KEY_LEFT   = 0;
  localparam int KEY_RIGHT  = 1;
  localparam int KEY_ROTATE = 2;
  localparam int KEY_DROP   = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DAS    = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int         DEF_N_KEYS         = 4;
  localparam int         DEF_DEBOUNCE_TICKS = 2;
  localparam int         DEF_DAS_TICKS      = 17;
  localparam int         DEF_ARR_TICKS      = 5;
  localparam logic [3:0] DEF_REPEAT_MASK    = 4'b0011;

  // The timer only has to hold 0 .. max(DAS,ARR)-1; never let it collapse to 0 bits.
  function automatic int timer_width(input int das, input int arr);
    int m;
    m = (das > arr) ? das : arr;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one push button.
// It synchronizes the raw active-low level, debounces it on tick edges and runs
// the IDLE/DAS/REPEAT/HOLD auto-repeat machine.
//   clk, rst_n : system clock, async active-low reset
//   tick       : one-cycle sample strobe
//   key_n      : raw button, 0 = pressed, asynchronous
//   held       : debounced state, 1 = pressed (registered)
//   raw_pulse  : combinational, 1 on the tick edge that produces a command
module key_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int DAS_TICKS      = DEF_DAS_TICKS,
  parameter int ARR_TICKS      = DEF_ARR_TICKS,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_n,
  output logic held,
  output logic raw_pulse
);

  localparam int TW = timer_width(DAS_TICKS, ARR_TICKS);
  localparam int CW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [TW-1:0] DAS_LAST = TW'(DAS_TICKS - 1);
  localparam logic [TW-1:0] ARR_LAST = TW'(ARR_TICKS - 1);

  logic [1:0]    sync;
  logic          sample;
  logic [CW-1:0] db_cnt;
  logic          accept;
  logic [1:0]    state, state_next;
  logic [TW-1:0] timer, timer_next;

  // Reset to "released" so a button held through reset is seen as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_n};
  end

  assign sample = ~sync[1];

  // The counter is compared before incrementing, so a new level must be seen on
  // DEBOUNCE_TICKS consecutive ticks before held follows it.
  assign accept = tick && (sample != held) && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (tick) begin
      if (sample == held) begin
        db_cnt <= '0;
      end else if (accept) begin
        held   <= ~held;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  // An accepted release beats everything else; held is still 1 on that edge.
  always_comb begin
    state_next = state;
    timer_next = timer;
    raw_pulse  = 1'b0;
    if (tick) begin
      if (accept && held) begin
        state_next = ST_IDLE;
        timer_next = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              raw_pulse  = 1'b1;
              state_next = REPEAT_EN ? ST_DAS : ST_HOLD;
              timer_next = '0;
            end
          end
          ST_DAS: begin
            if (timer == DAS_LAST) begin
              raw_pulse  = 1'b1;
              timer_next = '0;
              state_next = ST_REPEAT;
            end else begin
              timer_next = timer + TW'(1);
            end
          end
          ST_REPEAT: begin
            if (timer == ARR_LAST) begin
              raw_pulse  = 1'b1;
              timer_next = '0;
            end else begin
              timer_next = timer + TW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

endmodule

// File: rtl/key_repeat.sv
// key_repeat: button front end for the game-logic FSM.
//   CLOCK_50    : 50 MHz system clock
//   resetn      : async active-low reset
//   tick_input  : 100 Hz one-cycle sample strobe
//   keys_n      : raw buttons, 0 = pressed (bit 0 left, 1 right, 2 rotate, 3 drop)
//   game_active : 1 = commands enabled, 0 = cmd_pulse held low
//   cmd_pulse   : one-cycle command strobes, high in the cycle after the tick edge
//   held        : debounced pressed state per button
module key_repeat
  import tetris_pkg::*;
#(
  parameter int                N_KEYS         = DEF_N_KEYS,
  parameter int                DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int                DAS_TICKS      = DEF_DAS_TICKS,
  parameter int                ARR_TICKS      = DEF_ARR_TICKS,
  parameter logic [N_KEYS-1:0] REPEAT_MASK    = DEF_REPEAT_MASK
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              tick_input,
  input  logic [N_KEYS-1:0] keys_n,
  input  logic              game_active,
  output logic [N_KEYS-1:0] cmd_pulse,
  output logic [N_KEYS-1:0] held
);

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] keep;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .DAS_TICKS      (DAS_TICKS),
      .ARR_TICKS      (ARR_TICKS),
      .REPEAT_EN      (REPEAT_MASK[g])
    ) u_ch (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .tick      (tick_input),
      .key_n     (keys_n[g]),
      .held      (held[g]),
      .raw_pulse (raw[g])
    );
  end

  // Left and right firing together cancel each other; the channels keep running.
  if (N_KEYS >= 2) begin : g_opp
    always_comb begin
      keep = raw;
      if (raw[KEY_LEFT] && raw[KEY_RIGHT]) begin
        keep[KEY_LEFT]  = 1'b0;
        keep[KEY_RIGHT] = 1'b0;
      end
    end
  end else begin : g_no_opp
    assign keep = raw;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)          cmd_pulse <= '0;
    else if (game_active) cmd_pulse <= keep;
    else                  cmd_pulse <= '0;
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: directed bench for key_repeat with short timing
// (debounce 2, DAS 3, ARR 2 ticks) and a tick every 20 clock cycles.
module tb_key_repeat;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_input = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic       game_active = 1'b1;
  logic [3:0] cmd_pulse;
  logic [3:0] held;

  int total = 0;
  int bad   = 0;

  key_repeat #(
    .N_KEYS         (4),
    .DEBOUNCE_TICKS (2),
    .DAS_TICKS      (3),
    .ARR_TICKS      (2),
    .REPEAT_MASK    (4'b0011)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .tick_input  (tick_input),
    .keys_n      (keys_n),
    .game_active (game_active),
    .cmd_pulse   (cmd_pulse),
    .held        (held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic ga);
    keys_n      = k;
    game_active = ga;
  endtask

  // 19 quiet cycles (no command may appear), then one tick; outputs are read
  // at the falling edge right after the tick edge.
  task automatic tickStep(input string tag, input logic [3:0] exp_pulse, input logic [3:0] exp_held);
    logic [3:0] stray;
    stray = 4'h0;
    repeat (19) begin
      @(negedge CLOCK_50);
      stray |= cmd_pulse;
    end
    tick_input = 1'b1;
    @(negedge CLOCK_50);
    tick_input = 1'b0;
    checkOutput({tag, " gap"}, stray, 4'h0);
    checkOutput({tag, " pulse"}, cmd_pulse, exp_pulse);
    checkOutput({tag, " held"}, held, exp_held);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge CLOCK_50);
    checkOutput("reset pulse", cmd_pulse, 4'h0);
    checkOutput("reset held", held, 4'h0);
    resetn = 1'b1;

    // idle keys
    for (int i = 1; i <= 10; i++)
      tickStep($sformatf("idle t%0d", i), 4'h0, 4'h0);

    // rotate: single press pulse, no repeat, silent release
    applyStimulus(4'hB, 1'b1);
    for (int i = 1; i <= 10; i++)
      tickStep($sformatf("rot t%0d", i), (i == 2) ? 4'h4 : 4'h0, (i >= 2) ? 4'h4 : 4'h0);
    applyStimulus(4'hF, 1'b1);
    tickStep("rot rel t1", 4'h0, 4'h4);
    tickStep("rot rel t2", 4'h0, 4'h0);

    // one-tick glitches on left never get through
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'hE, 1'b1);
      tickStep($sformatf("glitch lo%0d", i), 4'h0, 4'h0);
      applyStimulus(4'hF, 1'b1);
      tickStep($sformatf("glitch hi%0d", i), 4'h0, 4'h0);
    end

    // left held: press, DAS, then repeats every 2 ticks
    applyStimulus(4'hE, 1'b1);
    for (int i = 1; i <= 12; i++)
      tickStep($sformatf("das t%0d", i),
               (i == 2 || i == 5 || i == 7 || i == 9 || i == 11) ? 4'h1 : 4'h0,
               (i >= 2) ? 4'h1 : 4'h0);
    applyStimulus(4'hF, 1'b1);
    // release is still being debounced on tick 13, so the repeat due then fires
    tickStep("das rel t13", 4'h1, 4'h1);
    tickStep("das rel t14", 4'h0, 4'h0);

    // left+right+rotate together: opposite pair cancelled, rotate fires
    applyStimulus(4'h8, 1'b1);
    for (int i = 1; i <= 8; i++)
      tickStep($sformatf("opp t%0d", i), (i == 2) ? 4'h4 : 4'h0, (i >= 2) ? 4'h7 : 4'h0);
    applyStimulus(4'hF, 1'b1);
    tickStep("opp rel t1", 4'h0, 4'h7);
    tickStep("opp rel t2", 4'h0, 4'h0);

    // same with commands disabled: held still tracks
    applyStimulus(4'h8, 1'b0);
    for (int i = 1; i <= 6; i++)
      tickStep($sformatf("inact t%0d", i), 4'h0, (i >= 2) ? 4'h7 : 4'h0);
    applyStimulus(4'hF, 1'b0);
    tickStep("inact rel t1", 4'h0, 4'h7);
    tickStep("inact rel t2", 4'h0, 4'h0);
    applyStimulus(4'hF, 1'b1);

    // left held into REPEAT, then async reset right after a pulse
    applyStimulus(4'hE, 1'b1);
    for (int i = 1; i <= 5; i++)
      tickStep($sformatf("rst pre t%0d", i),
               (i == 2 || i == 5) ? 4'h1 : 4'h0, (i >= 2) ? 4'h1 : 4'h0);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async rst pulse", cmd_pulse, 4'h0);
    checkOutput("async rst held", held, 4'h0);
    repeat (3) @(negedge CLOCK_50);
    #2 resetn = 1'b1;
    // key still held: must re-debounce and give a fresh press
    tickStep("rst post t1", 4'h0, 4'h0);
    tickStep("rst post t2", 4'h1, 4'h1);
    tickStep("rst post t3", 4'h0, 4'h1);
    applyStimulus(4'hF, 1'b1);
    tickStep("rst rel t1", 4'h0, 4'h1);
    tickStep("rst rel t2", 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_repeat.md
Name: key_repeat

Overview:
- Consumes the 10 ms input tick (100 Hz strobe, one CLOCK_50 cycle wide) and the raw active-low KEY buttons.
- Per button: synchronizes, debounces on tick boundaries, and runs a delayed-auto-repeat (DAS/ARR) state machine.
- Emits one-cycle move/rotate/drop command pulses to the game-logic FSM, which also consumes the gravity tick.

Parameters:
N_KEYS, 4, number of button channels (bit 0 left, 1 right, 2 rotate, 3 hard drop)
DEBOUNCE_TICKS, 2, consecutive ticks a changed level must persist before acceptance
DAS_TICKS, 17, ticks from accepted press to first repeat (170 ms)
ARR_TICKS, 5, ticks between subsequent repeats (50 ms)
REPEAT_MASK, 4'b0011, per-channel auto-repeat enable (left/right only)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
resetn  input  1  reset, asynchronous, active-low
tick_input  input  1  100 Hz single-cycle sample strobe
keys_n  input  N_KEYS  raw push buttons, 0 = pressed, asynchronous to CLOCK_50
game_active  input  1  1 = commands enabled; 0 = cmd_pulse masked, FSMs keep running
cmd_pulse  output  N_KEYS  one-cycle command strobes
held  output  N_KEYS  debounced pressed state, 1 = pressed

Behaviour:
- Reset (async assert, sync release): cmd_pulse=0, held=0, sync flops=1 (released), all debounce counters/timers=0, every channel in IDLE.
- Synchronizer: 2-flop per bit on keys_n. Only the second flop is used downstream.
- Debounce runs only on edges with tick_input=1:
  - sample == held: counter cleared.
  - sample != held: counter++. When the counter reaches DEBOUNCE_TICKS-1 on this tick, held flips and the counter clears.
  - Glitches shorter than DEBOUNCE_TICKS ticks never change held.
- Channel FSM states: IDLE, DAS, REPEAT, HOLD. Timer width = clog2(max(DAS_TICKS,ARR_TICKS)).
  - IDLE, press accepted: raw pulse; go to DAS if REPEAT_MASK bit set, else HOLD; timer=0.
  - DAS, each tick: if timer==DAS_TICKS-1, raw pulse, timer=0, go to REPEAT; else timer++.
  - REPEAT, each tick: if timer==ARR_TICKS-1, raw pulse, timer=0; else timer++.
  - HOLD: no pulses.
  - Release accepted in any state: go to IDLE, timer=0, no pulse.
- Latency:
  - Raw pulse is registered: cmd_pulse is high exactly during the cycle after the tick edge that caused it.
  - First command appears DEBOUNCE_TICKS ticks after the synchronized level change.
- Opposite-direction rule: if raw pulses for bit 0 and bit 1 occur on the same edge, both are dropped. Their FSMs still advance normally. Other bits are unaffected.
- cmd_pulse = raw pulse AND game_active, sampled on the same edge.
- tick_input stuck high: behaviour stays defined, with one tick per cycle. No assumption of tick spacing.
- Reset mid-operation: outputs drop immediately. A key held through reset must re-debounce and then generates a fresh press pulse.

Decomposition:
- Shared package tetris_pkg holds:
  - KEY_LEFT=0, KEY_RIGHT=1, KEY_ROTATE=2, KEY_DROP=3
  - channel state encoding (IDLE, DAS, REPEAT, HOLD)
  - default timing constants
- Sub-module key_channel: one button's synchronizer, debounce, FSM and raw pulse. It is instantiated N_KEYS times via generate, with REPEAT_MASK bit as a parameter.
- Top level adds the opposite-direction suppression and game_active masking.

Test Plan:
Bench params for all rows: DEBOUNCE_TICKS=2, DAS_TICKS=3, ARR_TICKS=2, ticks spaced 20 cycles, game_active=1 unless stated.
1. Reset, then keys_n=4'hF for 10 ticks -> cmd_pulse=0 and held=0 throughout.
2. keys_n[2]=0 held 10 ticks (ticks numbered after sync) -> single 1-cycle cmd_pulse[2] after tick 2, held[2]=1 from tick 2. After release, held[2]=0 two ticks later with no pulse.
3. keys_n[0] low for 1 tick, high 1 tick, repeated 8 times -> held[0] stays 0, no cmd_pulse[0].
4. keys_n[0] held 12 ticks -> cmd_pulse[0] after ticks 2, 5, 7, 9, 11 only (5 pulses).
5. keys_n[1:0]=0 on the same cycle, with keys_n[2]=0 -> no cmd_pulse[1:0], held[1:0]=2'b11, cmd_pulse[2] fires once. Repeat with game_active=0 -> all cmd_pulse stay 0 while held still tracks.
6. keys_n[0] held into REPEAT; assert resetn=0 mid-cycle, between clock edges -> held and cmd_pulse go 0 without a clock edge. Release reset with key still held -> cmd_pulse[0] again after tick 2.
